// File: rtl/mem_bus_responder_if.sv
// Controller-to-memory request/ack bus for mem_bus_responder.
// 4-phase handshake: the master raises req with we/addr/wdata stable. The slave answers
// with a one-cycle ack (rdata/err valid in that cycle). The master then drops req, and
// the slave accepts nothing new until it has seen req low.
interface mem_bus_responder_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          err;

    modport master (output req, we, addr, wdata, input ack, rdata, busy, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, busy, err);
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side responder: latches a request, waits WAIT_CYCLES, then acks with read data.
// Optional write protection of addresses 0..PROTECT_TOP via MEMRESP_WRITE_PROTECT_EN.
module mem_bus_responder #(
    parameter int            DW          = 16,
    parameter int            AW          = 8,
    parameter int            WAIT_CYCLES = 2,
    parameter logic [AW-1:0] PROTECT_TOP = 'h0F
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_bus_responder_if.slave      bus,
    output logic [1:0]              dbg_state_o
);

`ifdef MEMRESP_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic          prot_q;
    logic          ack_q;
    logic          busy_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;
    logic          prot_in;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    assign prot_in = PROT_EN && bus.we && (bus.addr <= PROTECT_TOP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            prot_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        we_q    <= bus.we;
                        prot_q  <= prot_in;
                        busy_q  <= 1'b1;
                        // Zero wait states: the ACK cycle follows acceptance directly,
                        // so the read uses the live address (identical to the latched one).
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_ACK;
                            ack_q   <= 1'b1;
                            err_q   <= prot_in;
                            cnt_q   <= '0;
                            if (!bus.we) rdata_q <= mem[bus.addr];
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_LD;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                        err_q   <= prot_q;
                        cnt_q   <= '0;
                        if (!we_q) rdata_q <= mem[addr_q];
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACK: state_q <= S_RELEASE;
                S_RELEASE: begin
                    if (!bus.req) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // RAM is not reset; a write commits only at the edge that ends its ACK cycle.
    always_ff @(posedge clk) begin
        if (state_q == S_ACK && we_q && !prot_q) mem[addr_q] <= wdata_q;
    end

    assign bus.ack     = ack_q;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = busy_q;
    assign bus.err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: transaction-level model checked every cycle plus directed
// literal expectations; a second instance covers the zero-wait-state build.
module tb_mem_bus_responder;

`ifdef MEMRESP_WRITE_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif
  localparam int W = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state0;
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  mem_bus_responder_if #(.DW(16), .AW(8)) bus ();
  mem_bus_responder_if #(.DW(16), .AW(8)) bus0 ();

  mem_bus_responder #(.DW(16), .AW(8), .WAIT_CYCLES(W), .PROTECT_TOP(8'h0F)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state_o(dbg_state)
  );
  mem_bus_responder #(.DW(16), .AW(8), .WAIT_CYCLES(0), .PROTECT_TOP(8'h0F)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .dbg_state_o(dbg_state0)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // model: one transaction at a time, ack W edges after the accepting edge
  logic [15:0] model_mem [0:255];
  bit          engaged = 1'b0;
  int          edge_n = 0;
  int          ack_edge = 0;
  logic [7:0]  lat_addr = '0;
  logic [15:0] lat_wdata = '0;
  bit          lat_we = 1'b0;
  bit          lat_prot = 1'b0;
  logic        exp_ack = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_err = 1'b0;
  logic [15:0] exp_rdata = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      engaged = 1'b0;
      exp_ack = 1'b0;
      exp_busy = 1'b0;
      exp_err = 1'b0;
      exp_rdata = '0;
    end else begin
      edge_n++;
      if (engaged && edge_n == ack_edge + 1 && lat_we && !lat_prot) model_mem[lat_addr] = lat_wdata;
      if (engaged && edge_n >= ack_edge + 2 && !bus.req) begin
        engaged = 1'b0;
      end else if (!engaged && bus.req) begin
        engaged = 1'b1;
        lat_addr = bus.addr;
        lat_wdata = bus.wdata;
        lat_we = bus.we;
        lat_prot = PROT_EN && bus.we && (bus.addr <= 8'h0F);
        ack_edge = edge_n + W;
      end
      exp_ack = engaged && (edge_n == ack_edge);
      exp_busy = engaged;
      exp_err = exp_ack && lat_we && lat_prot;
      if (exp_ack && !lat_we) exp_rdata = model_mem[lat_addr];
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ack", bus.ack, exp_ack);
      chk("cyc_busy", bus.busy, exp_busy);
      chk("cyc_err", bus.err, exp_err);
      if (!$isunknown(exp_rdata)) chk("cyc_rdata", bus.rdata, exp_rdata);
    end
  end

  // driver: one full 4-phase transaction on the W=2 instance
  task automatic txn(input bit w, input logic [7:0] a, input logic [15:0] d, input int hold,
                     input bit drop_early, input bit scramble,
                     output int lat, output logic [15:0] rd, output logic er, output int extra);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    lat = 0; rd = '0; er = 1'b0; extra = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.ack) begin
        lat = i; rd = bus.rdata; er = bus.err;
        break;
      end
      if (i == 1 && drop_early) bus.req = 1'b0;
      if (i == 1 && scramble) begin bus.addr = ~a; bus.wdata = ~d; end
    end
    if (lat == 0) chk("ack_timeout", 32'd0, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.ack) extra++;
    end
    bus.req = 1'b0;
    @(negedge clk);
  endtask

  int lat, extra;
  logic [15:0] rd;
  logic er;

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", bus.ack, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rdata", bus.rdata, 16'h0000);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // write 0x20 <= BEEF: ack in third cycle after acceptance
    txn(1'b1, 8'h20, 16'hBEEF, 0, 1'b0, 1'b0, lat, rd, er, extra);
    chk("wr20_latency", lat, 32'd3);
    // read back, rdata holds after req drops
    txn(1'b0, 8'h20, 16'h0000, 0, 1'b0, 1'b0, lat, rd, er, extra);
    chk("rd20_latency", lat, 32'd3);
    chk("rd20_data", rd, 16'hBEEF);
    repeat (5) @(negedge clk);
    chk("rd20_hold", bus.rdata, 16'hBEEF);

    // req held 6 cycles after ack: no second ack, then a fresh transaction
    txn(1'b0, 8'h20, 16'h0000, 6, 1'b0, 1'b0, lat, rd, er, extra);
    chk("hold_no_reack", extra, 32'd0);
    txn(1'b0, 8'h20, 16'h0000, 0, 1'b0, 1'b0, lat, rd, er, extra);
    chk("reassert_latency", lat, 32'd3);

    // boundary patterns; writes leave rdata untouched
    txn(1'b1, 8'hFF, 16'hFFFF, 1, 1'b0, 1'b0, lat, rd, er, extra);
    chk("wrFF_rdata_kept", bus.rdata, 16'hBEEF);
    txn(1'b1, 8'h10, 16'h0001, 0, 1'b0, 1'b0, lat, rd, er, extra);
    txn(1'b1, 8'h0F, 16'h7E7E, 0, 1'b0, 1'b0, lat, rd, er, extra);
    txn(1'b0, 8'hFF, 16'h0000, 0, 1'b0, 1'b0, lat, rd, er, extra);
    chk("rdFF_data", rd, 16'hFFFF);
    txn(1'b0, 8'h10, 16'h0000, 0, 1'b0, 1'b0, lat, rd, er, extra);
    chk("rd10_data", rd, 16'h0001);

    // address/data changed after acceptance are ignored
    txn(1'b1, 8'h40, 16'h1357, 0, 1'b0, 1'b1, lat, rd, er, extra);
    txn(1'b1, 8'hBF, 16'h2222, 0, 1'b0, 1'b0, lat, rd, er, extra);
    txn(1'b0, 8'h40, 16'h0000, 0, 1'b0, 1'b0, lat, rd, er, extra);
    chk("latched_wr_data", rd, 16'h1357);
    txn(1'b0, 8'hBF, 16'h0000, 0, 1'b0, 1'b0, lat, rd, er, extra);
    chk("scrambled_addr_untouched", rd, 16'h2222);

    // req dropped during WAIT still completes
    txn(1'b0, 8'h20, 16'h0000, 0, 1'b1, 1'b0, lat, rd, er, extra);
    chk("drop_early_latency", lat, 32'd3);
    chk("drop_early_data", rd, 16'hBEEF);

    // reset in WAIT aborts an un-acked write
    txn(1'b1, 8'h21, 16'h0000, 0, 1'b0, 1'b0, lat, rd, er, extra);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 8'h21; bus.wdata = 16'h1234;
    @(negedge clk);
    #2;
    reset = 1'b1;
    bus.req = 1'b0;
    #1;
    chk("async_rst_ack", bus.ack, 1'b0);
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_rdata", bus.rdata, 16'h0000);
    chk("async_rst_err", bus.err, 1'b0);
    chk("async_rst_state", dbg_state, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ack) extra++;
    end
    chk("aborted_no_ack", extra, 32'd0);
    txn(1'b0, 8'h21, 16'h0000, 0, 1'b0, 1'b0, lat, rd, er, extra);
    chk("aborted_wr_not_committed", rd, 16'h0000);

    // write protection
    txn(1'b1, 8'h05, 16'hAAAA, 0, 1'b0, 1'b0, lat, rd, er, extra);
    chk("wr05_latency", lat, 32'd3);
    txn(1'b0, 8'h05, 16'h0000, 0, 1'b0, 1'b0, lat, rd, er, extra);
`ifdef MEMRESP_WRITE_PROTECT_EN
    chk("wr05_prot_unchanged", (rd !== 16'hAAAA), 1'b1);
`else
    chk("rd05_data", rd, 16'hAAAA);
`endif
    txn(1'b1, 8'h05, 16'hAAAA, 0, 1'b0, 1'b0, lat, rd, er, extra);
    chk("wr05_err", er, PROT_EN);

    // zero-wait-state instance: ack in the cycle right after acceptance
    @(negedge clk);
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 8'h30; bus0.wdata = 16'h5A5A;
    @(negedge clk);
    chk("w0_wr_ack", bus0.ack, 1'b1);
    chk("w0_wr_busy", bus0.busy, 1'b1);
    bus0.req = 1'b0;
    @(negedge clk);
    chk("w0_wr_ack_low", bus0.ack, 1'b0);
    @(negedge clk);
    chk("w0_idle_busy", bus0.busy, 1'b0);
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 8'h30;
    @(negedge clk);
    chk("w0_rd_ack", bus0.ack, 1'b1);
    chk("w0_rd_data", bus0.rdata, 16'h5A5A);
    bus0.req = 1'b0;
    @(negedge clk);
    chk("w0_rd_ack_low", bus0.ack, 1'b0);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
